uart_byte_tx: RTL

//   8N1 UART serializer directly downstream of the message-fragmenting FSM.
//   The FSM presents one ASCII byte with a start strobe; this block frames it
//   (start, 8 data LSB-first, stop) at the configured baud and drives the pin.
//   It reports busy/done so the FSM can step to the next character.

---
 rtl/uart_byte_tx.sv | 118 +++++++++++
 1 files changed

// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter: frames one byte (start, 8 data bits LSB-first, stop)
// at CLKS_PER_BIT clocks per bit and reports busy/done to the upstream FSM.
module uart_byte_tx #(
   parameter int CLK_FREQ     = 100_000_000,
   parameter int BAUD         = 9600,
   parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       tx_start,
   output logic       busy,
   output logic       done,
   output logic       txd,
   output logic [1:0] fsm_state
);

   localparam int CW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          bit_last;
   logic [2:0]    next_idx;

   assign fsm_state = state;

   always_comb begin
      bit_last = (baud_cnt == CW'(CLKS_PER_BIT - 1));
      next_idx = bit_idx + 3'd1;
   end

   // Handshake: a request is taken on any edge where the block is free (IDLE,
   // or the final edge of STOP); requests seen while a frame is running are dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         txd      <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= 3'd0;
         shreg    <= 8'h00;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               if (tx_start) begin
                  shreg <= data;
                  state <= START;
                  txd   <= 1'b0;
                  busy  <= 1'b1;
               end else begin
                  txd  <= 1'b1;
                  busy <= 1'b0;
               end
            end
            START: begin
               if (bit_last) begin
                  baud_cnt <= '0;
                  bit_idx  <= 3'd0;
                  txd      <= shreg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            DATA: begin
               if (bit_last) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     bit_idx <= 3'd0;
                     txd     <= 1'b1;
                     state   <= STOP;
                  end else begin
                     bit_idx <= next_idx;
                     txd     <= shreg[next_idx];
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            STOP: begin
               if (bit_last) begin
                  baud_cnt <= '0;
                  done     <= 1'b1;
                  // A request on the closing edge starts the next frame with no idle gap.
                  if (tx_start) begin
                     shreg <= data;
                     state <= START;
                     txd   <= 1'b0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               txd   <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
